egress_ctrl: RTL

// - Egress counterpart of the ingress DDR writer: fetches stored packets from DDR through an AXI4 read master
//   and replays each one as a single AXI-Stream packet.
// - Per packet, the block accepts a descriptor {DDR byte address, byte length} and issues AXI read bursts.
// - Bursts are split on MAX_BURST and on 4KB boundaries.
// - Returned R beats are forwarded to m_axis with TLAST/TKEEP derived from the length.

---
 rtl/egress_ctrl_if.sv | 57 +++++
 rtl/egress_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/egress_ctrl_if.sv
// rtl/egress_ctrl_if.sv - descriptor, AXI4 read and AXI-Stream bundle for egress_ctrl
interface egress_ctrl_if #(
  parameter int ADDR_WIDTH = 31,
  parameter int DATA_WIDTH = 512,
  parameter int ID_WIDTH   = 4
);
  // descriptor channel
  logic [ADDR_WIDTH-1:0]   desc_addr;
  logic [15:0]             desc_len;
  logic                    desc_valid;
  logic                    desc_ready;
  // AXI4 read address channel
  logic [ID_WIDTH-1:0]     m_axi_arid;
  logic [ADDR_WIDTH-1:0]   m_axi_araddr;
  logic [7:0]              m_axi_arlen;
  logic [2:0]              m_axi_arsize;
  logic [1:0]              m_axi_arburst;
  logic                    m_axi_arvalid;
  logic                    m_axi_arready;
  // AXI4 read data channel
  logic [ID_WIDTH-1:0]     m_axi_rid;
  logic [DATA_WIDTH-1:0]   m_axi_rdata;
  logic [1:0]              m_axi_rresp;
  logic                    m_axi_rlast;
  logic                    m_axi_rvalid;
  logic                    m_axi_rready;
  // outgoing packet stream
  logic [DATA_WIDTH-1:0]   m_axis_tdata;
  logic [DATA_WIDTH/8-1:0] m_axis_tkeep;
  logic                    m_axis_tlast;
  logic                    m_axis_tvalid;
  logic                    m_axis_tready;

  // egress block side
  modport master (
    input  desc_addr, desc_len, desc_valid,
    output desc_ready,
    output m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arvalid,
    input  m_axi_arready,
    input  m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
    output m_axi_rready,
    output m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tvalid,
    input  m_axis_tready
  );

  // memory / stream sink / descriptor source side
  modport slave (
    output desc_addr, desc_len, desc_valid,
    input  desc_ready,
    input  m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arvalid,
    output m_axi_arready,
    output m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
    input  m_axi_rready,
    input  m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tvalid,
    output m_axis_tready
  );
endinterface

// File: rtl/egress_ctrl.sv
// rtl/egress_ctrl.sv - DDR-to-stream packet replay via AXI4 read bursts (optional: EGRESS_RLAST_CHECK_EN)
module egress_ctrl #(
  parameter int ADDR_WIDTH      = 31,
  parameter int DATA_WIDTH      = 512,
  parameter int ID_WIDTH        = 4,
  parameter int MAX_BURST       = 64,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  egress_ctrl_if.master bus,
  output logic [15:0]  pkt_cnt,
  output logic         rd_err
);
  localparam int BEAT_BYTES = DATA_WIDTH / 8;
  localparam int KEEP_W     = BEAT_BYTES;
  localparam int BYTE_SHIFT = $clog2(BEAT_BYTES);
  // 16-bit byte length divided by the beat size always fits here
  localparam int BEATS_W    = 17;
  localparam int OUT_W      = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADDR,
    S_DATA
  } state_t;

  state_t                 state;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [BEATS_W-1:0]     rem_q;
  logic [BEATS_W-1:0]     tot_q;
  logic [BEATS_W-1:0]     beat_cnt;
  logic [KEEP_W-1:0]      last_keep;
  logic [OUT_W-1:0]       outstanding;
  logic [OUT_W-1:0]       out_next;
  logic                   arvalid_q;
  logic                   desc_ready_q;

  logic                   active;
  logic                   ar_hs;
  logic                   r_hs;
  logic                   desc_hs;
  logic                   last_beat;
  logic                   tlast_c;
  logic                   rlast_err;
  logic [12:0]            room_bytes;
  logic [BEATS_W-1:0]     room_beats;
  logic [BEATS_W-1:0]     burst_c;
  logic [BEATS_W-1:0]     desc_beats;
  logic [BYTE_SHIFT-1:0]  desc_rem;
  logic [KEEP_W-1:0]      desc_keep;
  logic                   unused_rid;

  assign unused_rid = ^bus.m_axi_rid;

  assign active    = (state != S_IDLE);
  assign ar_hs     = arvalid_q && bus.m_axi_arready;
  assign r_hs      = bus.m_axi_rvalid && bus.m_axi_rready;
  assign desc_hs   = bus.desc_valid && desc_ready_q;
  assign last_beat = (beat_cnt == tot_q - 1'b1);
  assign tlast_c   = active && last_beat;

  // descriptor beat count and last-beat byte mask
  assign desc_beats = (BEATS_W'(bus.desc_len) + BEATS_W'(BEAT_BYTES - 1)) >> BYTE_SHIFT;
  assign desc_rem   = bus.desc_len[BYTE_SHIFT-1:0];
  assign desc_keep  = (desc_rem == '0) ? {KEEP_W{1'b1}}
                                       : ({KEEP_W{1'b1}} >> (KEEP_W - int'(desc_rem)));

  // burst size: remaining beats clipped by MAX_BURST and the next 4KB boundary
  assign room_bytes = 13'd4096 - {1'b0, addr_q[11:0]};
  assign room_beats = BEATS_W'(room_bytes >> BYTE_SHIFT);

  always_comb begin
    burst_c = rem_q;
    if (burst_c > BEATS_W'(MAX_BURST)) burst_c = BEATS_W'(MAX_BURST);
    if (burst_c > room_beats)          burst_c = room_beats;
  end

  // bursts in flight: AR accepted adds one, the closing R beat removes one
  always_comb begin
    out_next = outstanding;
    case ({ar_hs, r_hs && bus.m_axi_rlast})
      2'b10:   out_next = outstanding + 1'b1;
      2'b01:   out_next = outstanding - 1'b1;
      default: out_next = outstanding;
    endcase
  end

`ifdef EGRESS_RLAST_CHECK_EN
  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  logic [7:0]       len_fifo [MAX_OUTSTANDING];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [7:0]       burst_beat;

  // rlast must coincide exactly with the beat the burst length predicts
  assign rlast_err = r_hs && (bus.m_axi_rlast != (burst_beat == len_fifo[rd_ptr]));

  // burst length storage, written as each AR is accepted
  always_ff @(posedge clk) begin
    if (ar_hs) len_fifo[wr_ptr] <= bus.m_axi_arlen;
  end

  // FIFO pointers and the beat position inside the current returning burst
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      burst_beat <= '0;
    end else begin
      if (ar_hs)
        wr_ptr <= (wr_ptr == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : wr_ptr + 1'b1;
      if (r_hs) begin
        if (bus.m_axi_rlast) begin
          burst_beat <= '0;
          rd_ptr     <= (rd_ptr == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : rd_ptr + 1'b1;
        end else begin
          burst_beat <= burst_beat + 1'b1;
        end
      end
    end
  end
`else
  assign rlast_err = 1'b0;
`endif

  // control FSM, address generator, packet framing counters and status
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      addr_q       <= '0;
      rem_q        <= '0;
      tot_q        <= '0;
      beat_cnt     <= '0;
      last_keep    <= '0;
      outstanding  <= '0;
      arvalid_q    <= 1'b0;
      desc_ready_q <= 1'b0;
      pkt_cnt      <= '0;
      rd_err       <= 1'b0;
    end else begin
      outstanding <= out_next;
      if (r_hs && ((bus.m_axi_rresp != 2'b00) || rlast_err)) rd_err <= 1'b1;
      if (r_hs && tlast_c) pkt_cnt <= pkt_cnt + 1'b1;
      if (r_hs) beat_cnt <= beat_cnt + 1'b1;

      case (state)
        S_IDLE: begin
          desc_ready_q <= 1'b1;
          arvalid_q    <= 1'b0;
          if (desc_hs && (bus.desc_len != 16'd0)) begin
            addr_q       <= bus.desc_addr;
            rem_q        <= desc_beats;
            tot_q        <= desc_beats;
            beat_cnt     <= '0;
            last_keep    <= desc_keep;
            desc_ready_q <= 1'b0;
            arvalid_q    <= 1'b1;
            state        <= S_ADDR;
          end
        end
        S_ADDR: begin
          desc_ready_q <= 1'b0;
          if (arvalid_q) begin
            // payload stays put until the handshake
            if (ar_hs) begin
              addr_q <= addr_q + (ADDR_WIDTH'(burst_c) << BYTE_SHIFT);
              rem_q  <= rem_q - burst_c;
              if (rem_q == burst_c) begin
                arvalid_q <= 1'b0;
                state     <= S_DATA;
              end else begin
                arvalid_q <= (out_next < OUT_W'(MAX_OUTSTANDING));
              end
            end
          end else begin
            arvalid_q <= (out_next < OUT_W'(MAX_OUTSTANDING));
          end
        end
        S_DATA: begin
          desc_ready_q <= 1'b0;
          arvalid_q    <= 1'b0;
          if (r_hs && last_beat) begin
            desc_ready_q <= 1'b1;
            state        <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.desc_ready    = desc_ready_q;
  assign bus.m_axi_arid    = '0;
  assign bus.m_axi_araddr  = addr_q;
  assign bus.m_axi_arlen   = 8'(burst_c - 1'b1);
  assign bus.m_axi_arsize  = 3'(BYTE_SHIFT);
  assign bus.m_axi_arburst = 2'b01;
  assign bus.m_axi_arvalid = arvalid_q;

  // zero-latency pass-through of R onto the stream while a packet is open
  assign bus.m_axi_rready  = bus.m_axis_tready && active;
  assign bus.m_axis_tvalid = bus.m_axi_rvalid && active;
  assign bus.m_axis_tdata  = bus.m_axi_rdata;
  assign bus.m_axis_tlast  = tlast_c;
  assign bus.m_axis_tkeep  = tlast_c ? last_keep : {KEEP_W{1'b1}};
endmodule
